// File: rtl/miriscv_lsu_pkg.sv
// miriscv_lsu_pkg
// Shared definitions for the load/store unit: RISC-V funct3 size codes,
// the LSU FSM state encoding and the alignment check used by the top level.
package miriscv_lsu_pkg;

  // funct3 encodings of the load/store width
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // Unknown size codes fall into the default branch, so they are checked
  // as full words.
  function automatic logic is_misaligned(input logic [2:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      LDST_B, LDST_BU: return 1'b0;
      LDST_H, LDST_HU: return addr_lo[0];
      default:         return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/miriscv_lsu_align.sv
// miriscv_lsu_align
// Combinational datapath of the LSU: byte-enable and store-lane
// replication for the request side, lane selection and sign/zero extension
// for the response side.
//   size       in   funct3 access size
//   addr_lo    in   address bits [1:0]
//   store_data in   rs2 value to be stored
//   read_word  in   word returned by memory
//   be         out  byte enables
//   wdata      out  lane-replicated store data
//   load_data  out  extended load result
module miriscv_lsu_align
  import miriscv_lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] read_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = read_word[7:0];
    case (addr_lo)
      2'd0: byte_sel = read_word[7:0];
      2'd1: byte_sel = read_word[15:8];
      2'd2: byte_sel = read_word[23:16];
      2'd3: byte_sel = read_word[31:24];
      default: byte_sel = read_word[7:0];
    endcase
    half_sel = addr_lo[1] ? read_word[31:16] : read_word[15:0];

    // Word behaviour is the default so that illegal size codes act as W.
    be        = 4'b1111;
    wdata     = store_data;
    load_data = read_word;
    case (size)
      LDST_B: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{byte_sel[7]}}, byte_sel};
      end
      LDST_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {24'h000000, byte_sel};
      end
      LDST_H: begin
        be        = 4'b0011 << addr_lo;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{half_sel[15]}}, half_sel};
      end
      LDST_HU: begin
        be        = 4'b0011 << addr_lo;
        wdata     = {2{store_data[15:0]}};
        load_data = {16'h0000, half_sel};
      end
      default: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = read_word;
      end
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// miriscv_lsu
// Load/store unit sitting after the ALU. Issues one data-memory access per
// accepted request, stalls the core until the response (or a timeout), then
// spends one DONE cycle with stall released so the instruction retires.
//   clk_i, rst_i           clock, asynchronous active-high reset
//   lsu_req_i/we/size/addr/data_i  request from decode/ALU
//   lsu_data_o             registered, extended load result
//   lsu_stall_req_o        hold the pipeline this cycle
//   lsu_misalign_o         misaligned request seen in IDLE
//   lsu_fault_o            one-cycle pulse on memory timeout
//   data_*                 data-memory request/response interface
module miriscv_lsu
  import miriscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_misalign_o,
  output logic        lsu_fault_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_rvalid_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       size_reg;
  logic [1:0]       addr_lo_reg;

  logic        misalign;
  logic        busy;
  logic [2:0]  align_size;
  logic [1:0]  align_addr;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] align_load;

  assign misalign = is_misaligned(lsu_size_i, lsu_addr_i[1:0]);
  assign busy     = (state_reg == LSU_BUSY);

  // One shared datapath: in IDLE it builds the request from the live
  // inputs, in BUSY it decodes the response using the captured size and
  // address so the core may change its inputs meanwhile.
  assign align_size = busy ? size_reg    : lsu_size_i;
  assign align_addr = busy ? addr_lo_reg : lsu_addr_i[1:0];

  miriscv_lsu_align u_align (
    .size       (align_size),
    .addr_lo    (align_addr),
    .store_data (lsu_data_i),
    .read_word  (data_rdata_i),
    .be         (align_be),
    .wdata      (align_wdata),
    .load_data  (align_load)
  );

  assign lsu_stall_req_o = lsu_req_i & ~misalign & (state_reg != LSU_DONE);
  assign lsu_misalign_o  = lsu_req_i & misalign & (state_reg == LSU_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= LSU_IDLE;
      cnt_reg      <= '0;
      size_reg     <= 3'd0;
      addr_lo_reg  <= 2'd0;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= 4'd0;
      data_addr_o  <= 32'd0;
      data_wdata_o <= 32'd0;
      lsu_data_o   <= 32'd0;
      lsu_fault_o  <= 1'b0;
    end else begin
      lsu_fault_o <= 1'b0;
      case (state_reg)
        LSU_IDLE: begin
          if (lsu_req_i && !misalign) begin
            data_req_o   <= 1'b1;
            data_we_o    <= lsu_we_i;
            data_be_o    <= align_be;
            data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
            data_wdata_o <= align_wdata;
            size_reg     <= lsu_size_i;
            addr_lo_reg  <= lsu_addr_i[1:0];
            cnt_reg      <= '0;
            state_reg    <= LSU_BUSY;
          end
        end
        LSU_BUSY: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          // A response in the last allowed cycle still wins over the timeout.
          if (data_rvalid_i) begin
            if (!data_we_o) begin
              lsu_data_o <= align_load;
            end
            data_req_o <= 1'b0;
            state_reg  <= LSU_DONE;
          end else if (TIMEOUT_CYCLES != 0 && cnt_reg == CNT_LAST) begin
            data_req_o  <= 1'b0;
            lsu_fault_o <= 1'b1;
            state_reg   <= LSU_DONE;
          end
        end
        LSU_DONE: begin
          state_reg <= LSU_IDLE;
        end
        default: begin
          state_reg <= LSU_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/miriscv_lsu.md
Name: miriscv_lsu

Overview:
- Load/store unit directly downstream of the ALU: takes the ALU result as the effective address, drives the data-memory request interface, and returns an aligned, sign/zero-extended load result to the writeback mux.
- Stalls the core while an access is outstanding.
- Flags misaligned addresses and memory timeouts instead of issuing or hanging.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles in BUSY waiting for data_rvalid_i; 0 disables the timeout.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- lsu_req_i  in  1  decoder requests a memory access this instruction
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_size_i  in  3  RISC-V funct3: B=0, H=1, W=2, BU=4, HU=5
- lsu_addr_i  in  32  effective address (ALU result_o)
- lsu_data_i  in  32  store data (rs2)
- lsu_data_o  out  32  extended load result, registered
- lsu_stall_req_o  out  1  hold PC/pipeline this cycle
- lsu_misalign_o  out  1  misaligned access detected (combinational)
- lsu_fault_o  out  1  one-cycle pulse on timeout
- data_req_o  out  1  memory request, registered
- data_we_o  out  1  memory write enable
- data_be_o  out  4  byte enables
- data_addr_o  out  32  word-aligned address {lsu_addr_i[31:2],2'b00}
- data_wdata_o  out  32  lane-replicated store data
- data_rdata_i  in  32  memory read word
- data_rvalid_i  in  1  response valid, for loads and stores

Behaviour:
- Reset: state IDLE, timeout counter 0; all outputs 0 (data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, lsu_data_o, lsu_fault_o).
- Misalign (combinational): H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - lsu_misalign_o = lsu_req_i & misalign & state==IDLE.
  - No access is issued and lsu_stall_req_o=0.
- Illegal lsu_size_i (3, 6, 7): treated as W.
- FSM states:
  - IDLE: on lsu_req_i & !misalign, register the memory-side outputs, set data_req_o=1, go to BUSY.
  - BUSY: hold data_req_o and all other memory-side outputs stable until data_rvalid_i.
    - On rvalid: for a load, register the extracted data into lsu_data_o; for a store, leave lsu_data_o unchanged. Clear data_req_o and go to DONE.
    - If the counter reaches TIMEOUT_CYCLES-1 without rvalid: clear data_req_o, pulse lsu_fault_o, go to DONE.
  - DONE: one cycle with stall deasserted so the core advances; then go to IDLE. An lsu_req_i seen in DONE is not accepted.
- lsu_stall_req_o = lsu_req_i & !misalign & (state != DONE), combinational.
  - Minimum access: rvalid in the first BUSY cycle gives 2 stall cycles, then a DONE cycle.
- Byte enables: B/BU = 4'b0001<<addr[1:0]; H/HU = 4'b0011<<addr[1:0]; W = 4'b1111. Identical for loads and stores.
- Store data: B = {4{d[7:0]}}; H = {2{d[15:0]}}; W = d.
- Load extraction:
  - Byte lane selected by the registered addr[1:0]; halfword by addr[1].
  - B/H sign-extend to 32 bits; BU/HU zero-extend; W passes through.
- Timeout counter: cleared on entry to BUSY, increments each BUSY cycle. With TIMEOUT_CYCLES=0 it never fires.
- data_rvalid_i outside BUSY is ignored.
- Reset mid-access (any state): immediate return to IDLE with reset output values; the outstanding response is dropped.

Decomposition:
- Shared defines header (alongside the ALU opcode defines): LDST_B/H/W/BU/HU size codes, FSM state encodings.
- One natural sub-module, miriscv_lsu_align: combinational be/wdata generation and load extraction/extension.
  - Inputs: size, addr[1:0], store data, read word.
  - Keeps the FSM wrapper small and lets the datapath be unit-tested exhaustively.

Test Plan:
- SW: addr=0x100, data=0xDEADBEEF, rvalid after 3 cycles -> data_be_o=1111, data_addr_o=0x100, data_wdata_o=0xDEADBEEF, stall high for 4 cycles, data_req_o held throughout.
- LB: addr=0x203, rdata=0x80FF_1234, rvalid next cycle -> be=1000, lsu_data_o=0xFFFFFF80. LBU at the same address and rdata -> lsu_data_o=0x00000080.
- LH: addr=0x12, rdata=0x8001_7FFF -> be=1100, lsu_data_o=0xFFFF8001. LHU at addr=0x10 -> lsu_data_o=0x00007FFF.
- Misalign: LW at addr=0x102, and SH at addr=0x101 -> lsu_misalign_o=1, data_req_o stays 0, stall=0.
- Timeout: TIMEOUT_CYCLES=4, LW with no rvalid -> data_req_o high 4 cycles, then lsu_fault_o 1-cycle pulse, DONE, IDLE.
  - A late rvalid in IDLE is ignored and lsu_data_o is unchanged.
- Reset mid-access: assert rst_i asynchronously during BUSY -> all outputs 0 before the next clock edge, state IDLE; a following SB at addr=0x3, data=0xAB gives be=1000, wdata=0xABABABAB.
